// File: rtl/s_vec_reader.sv
// s_vec_reader: streams one 256-coefficient secret polynomial from a 64-bit
// wide registered ROM, decoding sixteen 4-bit sign-magnitude nibbles per word
// into 13-bit two's-complement coefficients behind a valid/ready handshake.
module s_vec_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  s_address,
  input  logic [63:0] s_vec_64,
  output logic [12:0] coeff_out,
  output logic [7:0]  coeff_index,
  output logic        coeff_valid,
  input  logic        coeff_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [3:0]  nib_cnt_q, nib_cnt_d;
  logic [63:0] word_q, word_d;
  logic [12:0] coeff_q, coeff_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  nib_next;
  logic [63:0] word_shifted;

  // Sign-magnitude nibble to 13-bit two's complement; -0 falls out as 0.
  function automatic logic [12:0] decode_nib(input logic [3:0] nib);
    logic [12:0] mag;
    mag = {10'd0, nib[2:0]};
    return nib[3] ? (13'd0 - mag) : mag;
  endfunction

  assign nib_next     = nib_cnt_q + 4'd1;
  assign word_shifted = word_q >> {nib_next, 2'b00};

  // Next-state and datapath: the coefficient register is loaded one step
  // ahead so coeff_out is valid in the first EMIT cycle.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    nib_cnt_d  = nib_cnt_q;
    word_d     = word_q;
    coeff_d    = coeff_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_cnt_d = 4'd0;
          nib_cnt_d  = 4'd0;
          busy_d     = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d    = s_vec_64;
        nib_cnt_d = 4'd0;
        coeff_d   = decode_nib(s_vec_64[3:0]);
        valid_d   = 1'b1;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (coeff_ready) begin
          if (nib_cnt_q != 4'd15) begin
            nib_cnt_d = nib_next;
            coeff_d   = decode_nib(word_shifted[3:0]);
          end else begin
            valid_d = 1'b0;
            if (word_cnt_q != 4'd15) begin
              word_cnt_d = word_cnt_q + 4'd1;
              state_d    = S_REQ;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= 4'd0;
      nib_cnt_q  <= 4'd0;
      word_q     <= 64'd0;
      coeff_q    <= 13'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      nib_cnt_q  <= nib_cnt_d;
      word_q     <= word_d;
      coeff_q    <= coeff_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_address   = {3'b000, word_cnt_q};
  assign coeff_index = {word_cnt_q, nib_cnt_q};
  assign coeff_out   = coeff_q;
  assign coeff_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_s_vec_reader.sv
// Bench for s_vec_reader: registered ROM model, transfer monitor with an
// arithmetic reference decoder, directed vectors and randomized runs.
module tb_s_vec_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  s_address;
  logic [63:0] s_vec_64;
  logic [12:0] coeff_out;
  logic [7:0]  coeff_index;
  logic        coeff_valid;
  logic        coeff_ready;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  logic [63:0] rom [16];
  logic [63:0] rom_q;
  logic [12:0] got_c [256];

  int exp_idx;
  int done_cnt;
  logic        prev_stall;
  logic [12:0] prev_out;
  logic [7:0]  prev_idx;
  logic [6:0]  prev_addr;

  typedef struct {
    int          idx;
    logic [12:0] exp;
  } vec_t;
  vec_t vecs [5];

  s_vec_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_address   (s_address),
    .s_vec_64    (s_vec_64),
    .coeff_out   (coeff_out),
    .coeff_index (coeff_index),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data for the address sampled at an edge appears after it.
  always_ff @(posedge clk) rom_q <= rom[s_address[3:0]];
  assign s_vec_64 = rom_q;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: coefficient i is nibble (i mod 16) of word (i / 16), read as
  // sign-magnitude and wrapped to 13 bits.
  function automatic logic [12:0] ref_coeff(input int i);
    logic [63:0] w;
    int n;
    int v;
    w = rom[i / 16];
    n = int'((w >> (4 * (i % 16))) & 64'hF);
    v = (n >= 8) ? -(n - 8) : n;
    return v[12:0];
  endfunction

  // Monitor: checks every transfer in order, stall hold, and done behaviour.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        exp_idx  = 0;
        done_cnt = 0;
      end
      if (prev_stall) begin
        check("hold_valid", coeff_valid, 1);
        check("hold_out", coeff_out, prev_out);
        check("hold_index", coeff_index, prev_idx);
        check("hold_addr", s_address, prev_addr);
      end
      if (coeff_valid && coeff_ready) begin
        if (exp_idx > 255) begin
          check("extra_xfer", exp_idx, 255);
        end else begin
          check("xfer_index", coeff_index, exp_idx);
          check("xfer_coeff", coeff_out, ref_coeff(exp_idx));
          check("xfer_addr", s_address, exp_idx / 16);
          got_c[exp_idx] = coeff_out;
        end
        exp_idx++;
      end
      if (done) begin
        done_cnt++;
        check("done_vs_valid", coeff_valid, 0);
      end
      prev_stall = coeff_valid && !coeff_ready;
      prev_out   = coeff_out;
      prev_idx   = coeff_index;
      prev_addr  = s_address;
    end
  end

  task automatic fill_rom();
    for (int w = 0; w < 16; w++) rom[w] = {$urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, s_address, 0);
    check({tag, "_coeff"}, coeff_out, 0);
    check({tag, "_index"}, coeff_index, 0);
    check({tag, "_valid"}, coeff_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One start pulse and a full stream, with optional stall, random ready,
  // a second start at restart_at, or a reset at rst_at.
  task automatic run_stream(input int stall_idx, input int stall_len, input bit rnd,
                            input int restart_at, input int rst_at, input bit timing);
    int  stall_cnt;
    int  first_v;
    int  done_cyc;
    bit  finished;
    stall_cnt = 0;
    first_v   = -1;
    done_cyc  = -1;
    finished  = 0;
    @(posedge clk); #1;
    start       = 1'b1;
    coeff_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (coeff_valid && coeff_index == stall_idx[7:0] && stall_idx >= 0 && stall_cnt < stall_len) begin
        coeff_ready = 1'b0;
        stall_cnt++;
      end else if (rnd) begin
        coeff_ready = ($urandom_range(3) != 0);
      end else begin
        coeff_ready = 1'b1;
      end
      start = (restart_at >= 0 && coeff_valid && coeff_index == restart_at[7:0]);
      if (rst_at >= 0 && coeff_valid && coeff_index == rst_at[7:0]) begin
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("postrst_valid", coeff_valid, 0);
          check("postrst_busy", busy, 0);
        end
        return;
      end
      @(negedge clk);
      if (coeff_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cyc = cyc;
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("stream_finished", finished, 1);
    repeat (5) @(negedge clk);
    check("xfer_count", exp_idx, 256);
    check("done_count", done_cnt, 1);
    check("busy_after", busy, 0);
    check("valid_after", coeff_valid, 0);
    if (timing) begin
      check("first_valid_latency", first_v, 2);
      check("req_to_done_cycles", done_cyc, 288);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_idx     = 0;
    done_cnt    = 0;
    prev_stall  = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    coeff_ready = 1'b0;
    fill_rom();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed word 0 vectors.
    vecs[0] = '{0, 13'h1FF9};
    vecs[1] = '{1, 13'h1FFA};
    vecs[2] = '{7, 13'h0000};
    vecs[3] = '{8, 13'h0007};
    vecs[4] = '{15, 13'h0000};
    fill_rom();
    rom[0] = 64'h0123456789ABCDEF;
    run_stream(-1, 0, 0, -1, -1, 1);
    for (int t = 0; t < 5; t++) begin
      check($sformatf("vec_idx%0d", vecs[t].idx), got_c[vecs[t].idx], vecs[t].exp);
    end

    // Full random run, then stalls mid-word and at the word boundary.
    fill_rom();
    run_stream(-1, 0, 0, -1, -1, 1);
    fill_rom();
    run_stream(37, 5, 0, -1, -1, 0);
    fill_rom();
    run_stream(15, 5, 0, -1, -1, 0);

    // Random backpressure.
    fill_rom();
    run_stream(-1, 0, 1, -1, -1, 0);

    // Second start while streaming is ignored.
    fill_rom();
    run_stream(-1, 0, 0, 50, -1, 1);

    // Reset at index 100, then a fresh stream from index 0.
    fill_rom();
    run_stream(-1, 0, 0, -1, 100, 0);
    run_stream(-1, 0, 0, -1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
